// File: rtl/mul_sequencer_if.sv
// Bus between the EX stage and the iterative multiplier.
// master: EX-stage side (drives operands/control, observes stall/done/result/busy)
// slave : mul_sequencer side
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             busy_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    input  stall_o, done_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    output stall_o, done_o, result_o, busy_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage: one multiplier bit per
// cycle, WIDTH RUN cycles, then a one-cycle DONE pulse with the low WIDTH
// bits of the product.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - mul_sequencer_if.slave: valid_i, ALUCtrl_i, data1_i, data2_i,
//            flush_i in; stall_o (combinational), done_o, result_o, busy_o out
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_sequencer_if.slave bus
);

  localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0]  ALU_MUL = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] acc_sum_c;

  // Qualified mul launch from IDLE; a concurrent flush kills it.
  always_comb begin
    accept_c  = (state_q == IDLE) && bus.valid_i && (bus.ALUCtrl_i == ALU_MUL) && !bus.flush_i;
    last_c    = (cnt_q == '0);
    acc_sum_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = RUN;
      RUN: begin
        if (bus.flush_i)  state_d = IDLE;
        else if (last_c)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift-add datapath; result captured on the final iteration so it stays
  // stable until the next completed product.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept_c) begin
      mcand_q  <= bus.data1_i;
      mplier_q <= bus.data2_i;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(WIDTH - 1);
    end else if ((state_q == RUN) && !bus.flush_i) begin
      acc_q    <= acc_sum_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (last_c) result_q <= acc_sum_c;
    end
  end

  // Stall is gated by reset so the pipeline is released while rst_i is low,
  // and drops in a RUN flush cycle.
  assign bus.stall_o  = rst_i && (accept_c || ((state_q == RUN) && !bus.flush_i));
  assign bus.done_o   = (state_q == DONE);
  assign bus.busy_o   = (state_q == RUN);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expected products,
// a monitor pops and compares on every done_o pulse.
module tb_mul_sequencer;
  localparam int unsigned WIDTH   = 32;
  localparam logic [2:0]  ALU_MUL = 3'b011;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus ();
  mul_sequencer #(.WIDTH(WIDTH)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               done_cyc[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_i   = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.flush_i   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive a mul in the current cycle T and check it is accepted.
  task automatic start_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp, input bit push);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = ALU_MUL;
    bus.data1_i   = a;
    bus.data2_i   = b;
    bus.flush_i   = 1'b0;
    if (push) exp_q.push_back(exp);
    @(negedge clk_i);
    check("accept_stall", WIDTH'(bus.stall_o), 1);
    check("accept_busy", WIDTH'(bus.busy_o), 0);
  endtask

  // Cycles T+1..T+32 (operands scrambled), then the DONE cycle T+33.
  task automatic run_to_done(input bit next_valid, input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
    int st;
    int bz;
    st = 0;
    bz = 0;
    for (int i = 1; i <= int'(WIDTH); i++) begin
      step();
      bus.data1_i = $urandom;
      bus.data2_i = $urandom;
      @(negedge clk_i);
      if (bus.stall_o === 1'b1) st++;
      if (bus.busy_o === 1'b1) bz++;
    end
    check("run_stall_cycles", WIDTH'(st), WIDTH'(WIDTH));
    check("run_busy_cycles", WIDTH'(bz), WIDTH'(WIDTH));
    step();
    bus.valid_i   = next_valid;
    bus.ALUCtrl_i = ALU_MUL;
    bus.data1_i   = na;
    bus.data2_i   = nb;
    @(negedge clk_i);
    check("done_pulse", WIDTH'(bus.done_o), 1);
    check("done_stall", WIDTH'(bus.stall_o), 0);
    check("done_busy", WIDTH'(bus.busy_o), 0);
  endtask

  task automatic full_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    start_mul(a, b, exp, 1'b1);
    run_to_done(1'b0, '0, '0);
    step();
    idle_inputs();
  endtask

  // Monitor: compares result_o against the scoreboard on each done pulse.
  initial begin
    forever begin
      @(negedge clk_i);
      if (bus.done_o === 1'b1) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result 0x%h with no product pending (cycle %0d)", bus.result_o, cyc);
        end else begin
          check("result", bus.result_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [2:0] codes[7];
    codes = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b100, 3'b101, 3'b111};
    idle_inputs();
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    #2;
    check("rst_stall", WIDTH'(bus.stall_o), 0);
    check("rst_done", WIDTH'(bus.done_o), 0);
    check("rst_busy", WIDTH'(bus.busy_o), 0);
    check("rst_result", bus.result_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    step();

    // Basic products including wraparound corners.
    full_mul(32'd7, 32'd6, 32'd42);
    full_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    full_mul(32'h8000_0000, 32'd2, 32'h0000_0000);
    full_mul(32'd0, 32'h1234, 32'd0);
    full_mul(32'd7, 32'd6, 32'd42);

    // Non-mul codes never stall or start.
    foreach (codes[k]) begin
      int hits;
      hits = 0;
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = codes[k];
      bus.data1_i   = $urandom;
      bus.data2_i   = $urandom;
      repeat (10) begin
        @(negedge clk_i);
        if (bus.stall_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) hits++;
        step();
      end
      check($sformatf("nonmul_%b", codes[k]), WIDTH'(hits), 0);
    end
    idle_inputs();
    step();

    // Flush mid-run at T+10: no done, result keeps 42.
    start_mul(32'd5, 32'd5, '0, 1'b0);
    repeat (9) step();
    step();
    bus.flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_stall", WIDTH'(bus.stall_o), 0);
    check("flush_busy", WIDTH'(bus.busy_o), 1);
    step();
    idle_inputs();
    @(negedge clk_i);
    check("post_flush_busy", WIDTH'(bus.busy_o), 0);
    check("post_flush_stall", WIDTH'(bus.stall_o), 0);
    repeat (40) step();
    check("flush_result_kept", bus.result_o, 32'd42);

    // Flush in the would-be accept cycle.
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = ALU_MUL;
    bus.data1_i   = 32'd2;
    bus.data2_i   = 32'd2;
    bus.flush_i   = 1'b1;
    @(negedge clk_i);
    check("flush_accept_stall", WIDTH'(bus.stall_o), 0);
    step();
    idle_inputs();
    @(negedge clk_i);
    check("flush_accept_busy", WIDTH'(bus.busy_o), 0);
    step();

    // Back-to-back: 3*3 then 9*9, second accepted right after DONE.
    start_mul(32'd3, 32'd3, 32'd9, 1'b1);
    run_to_done(1'b1, 32'd9, 32'd9);
    step();
    start_mul(32'd9, 32'd9, 32'd81, 1'b1);
    run_to_done(1'b0, '0, '0);
    step();
    idle_inputs();
    if (done_cyc.size() >= 2)
      check("b2b_done_spacing", WIDTH'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd34);
    else
      check("b2b_done_count", WIDTH'(done_cyc.size()), 2);

    // Asynchronous reset at T+15 of a multiply.
    start_mul(32'd7, 32'd8, '0, 1'b0);
    repeat (15) step();
    #2 rst_i = 1'b0;
    #1;
    check("midrst_stall", WIDTH'(bus.stall_o), 0);
    check("midrst_busy", WIDTH'(bus.busy_o), 0);
    check("midrst_done", WIDTH'(bus.done_o), 0);
    check("midrst_result", bus.result_o, 0);
    idle_inputs();
    step();
    rst_i = 1'b1;
    step();
    full_mul(32'd3, 32'd4, 32'd12);
    repeat (3) step();

    check("scoreboard_empty", WIDTH'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  EX stage holds a valid instruction this cycle.
REQ-005 ALUCtrl_i  input  3  ALU control code from ALU control decode; 3'b011 = mul.
REQ-006 data1_i  input  WIDTH  multiplicand (rs value).
REQ-007 data2_i  input  WIDTH  multiplier (rt value).
REQ-008 flush_i  input  1  abort in-flight multiply (branch/exception flush).
REQ-009 stall_o  output  1  freeze PC, IF/ID and ID/EX while high.
REQ-010 done_o  output  1  one-cycle pulse; result_o valid.
REQ-011 result_o  output  WIDTH  low WIDTH bits of the product.
REQ-012 busy_o  output  1  FSM in RUN.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-014 Accept = IDLE & valid_i & (ALUCtrl_i==3'b011) & ~flush_i.
REQ-015 On accept: latch data1_i -> mcand, data2_i -> mplier, clear acc, load iteration counter with WIDTH-1, go to RUN.
REQ-016 stall_o SHALL be combinational: high in the accept cycle and in every RUN cycle; low in IDLE (no accept) and DONE.
REQ-017 Each RUN cycle: if mplier[0] then acc <= acc + mcand (mod 2^WIDTH); mcand <= mcand << 1; mplier <= mplier >> 1; counter decrements.
REQ-018 RUN with counter==0 (after the WIDTH-th iteration) SHALL transition to DONE.
REQ-019 Latency: accept at cycle T -> done_o high at cycle T+WIDTH+1; stall_o high for exactly WIDTH+1 cycles (T..T+WIDTH).
REQ-020 DONE: done_o=1, result_o=acc; unconditionally return to IDLE next cycle; valid_i/ALUCtrl_i ignored in DONE.
REQ-021 result_o SHALL hold the last completed product until the next DONE; only low WIDTH bits are kept (signed and unsigned identical).
REQ-022 Non-mul ALUCtrl_i codes (010, 110, 000, 001, others) SHALL never assert stall_o, busy_o or done_o.
REQ-023 flush_i in RUN: next state IDLE, no done_o, result_o unchanged; stall_o drops in the flush cycle.
REQ-024 flush_i in the would-be accept cycle: no accept, stall_o low.
REQ-025 flush_i in DONE: ignored; done_o still pulses.
REQ-026 Back-to-back muls: second mul accepted no earlier than the cycle after DONE; gap of exactly one IDLE cycle (DONE) between stall windows.
REQ-027 Operand changes on data1_i/data2_i during RUN SHALL not affect the result.
REQ-028 busy_o = (state==RUN).

Reset
REQ-029 rst_i low SHALL immediately force IDLE, stall_o=0, done_o=0, busy_o=0, result_o=0, acc/mcand/mplier/counter=0.
REQ-030 Reset mid-RUN SHALL abandon the operation; after release the block accepts a new mul on the first qualifying edge.
REQ-031 No output SHALL be X after reset release.

Verification
REQ-032 WIDTH=32, valid_i=1, ALUCtrl_i=011, 7*6 at T -> stall_o high T..T+32, done_o at T+33, result_o=42.
REQ-033 0xFFFFFFFF*0xFFFFFFFF -> result_o=0x00000001; 0x80000000*2 -> 0x00000000; 0*0x1234 -> 0.
REQ-034 ALUCtrl_i=010/110/000/001 with valid_i=1 for 10 cycles -> stall_o, busy_o, done_o stay 0.
REQ-035 Accept 5*5, assert flush_i at T+10 -> state IDLE at T+11, stall_o low from T+10, no done_o, result_o keeps prior value.
REQ-036 Pull rst_i low at T+15 of a multiply -> all outputs 0 asynchronously; release, issue 3*4 -> result_o=12 after 33 cycles.
REQ-037 Two consecutive muls 3*3 then 9*9 (held in EX while stalled) -> done_o pulses 34 cycles apart, results 9 then 81.
